// File: rtl/adc_trig_capture.sv
// -----------------------------------------------------------------------------
// adc_trig_capture
//   Takes the 14-bit offset-binary ADC B stream and converts it to two's
//   complement. After an arm pulse it waits for a level-crossing trigger,
//   then records DEPTH = 2**AW consecutive samples into an on-chip RAM.
//   A registered read port lets downstream consumers fetch the record.
//   All logic runs on CLK_ADC.
//
// Optional build macro:
//   ADC_CAP_DECIM_EN : adds the 8-bit 'decim' input. A sample is taken once
//                      every decim+1 cycles. When the macro is undefined,
//                      every cycle is a sample cycle.
//
// Ports:
//   CLK_ADC     in   ADC sampling clock
//   RST_N       in   asynchronous active-low reset
//   adc_b       in   raw sample, offset binary
//   arm         in   one-cycle pulse that starts or restarts a capture
//   trig_mode   in   00 rising, 01 falling, 1x immediate
//   trig_level  in   signed trigger threshold
//   decim       in   decimation factor minus one (ADC_CAP_DECIM_EN only)
//   rd_addr     in   read address
//   rd_data     out  signed sample at rd_addr, one-cycle latency
//   busy        out  waiting for the trigger or capturing
//   done        out  record complete
//   wr_ptr      out  current write address
// -----------------------------------------------------------------------------
module adc_trig_capture #(
  parameter int DW = 14,
  parameter int AW = 9
) (
  input  logic          CLK_ADC,
  input  logic          RST_N,
  input  logic [DW-1:0] adc_b,
  input  logic          arm,
  input  logic [1:0]    trig_mode,
  input  logic [DW-1:0] trig_level,
`ifdef ADC_CAP_DECIM_EN
  input  logic [7:0]    decim,
`endif
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] wr_ptr
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          busy_q, done_q;
  logic          we;
  logic          sample_en;

  // ---------------------------------------------------------------------------
  // Sample strobe
  // ---------------------------------------------------------------------------
`ifdef ADC_CAP_DECIM_EN
  logic [7:0] dcnt_q;
  logic [7:0] decim_q;

  // decim is latched only when the counter wraps (or on arm), so a change
  // never shortens or stretches the interval that is already in progress.
  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      dcnt_q  <= '0;
      decim_q <= '0;
    end else if (arm) begin
      dcnt_q  <= '0;
      decim_q <= decim;
    end else if (dcnt_q == decim_q) begin
      dcnt_q  <= '0;
      decim_q <= decim;
    end else begin
      dcnt_q  <= dcnt_q + 8'd1;
    end
  end

  assign sample_en = (dcnt_q == '0);
`else
  assign sample_en = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Input stage: offset binary -> two's complement
  // ---------------------------------------------------------------------------
  logic [DW-1:0] s_cur, s_prev;
  logic          cur_valid, have_prev;

  // The data registers always follow the stream. Only the valid flags are
  // cleared by arm, so the samples held at arm time are never used for a
  // post-arm trigger decision.
  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      s_cur     <= '0;
      s_prev    <= '0;
      cur_valid <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      if (sample_en) begin
        s_cur  <= {~adc_b[DW-1], adc_b[DW-2:0]};
        s_prev <= s_cur;
      end
      if (arm) begin
        cur_valid <= 1'b0;
        have_prev <= 1'b0;
      end else if (sample_en && state_q == WAIT_TRIG) begin
        cur_valid <= 1'b1;
        have_prev <= cur_valid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Trigger detection (signed compares)
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] lvl_s, cur_s, prev_s;
  logic                 trig_hit;

  assign lvl_s  = trig_level;
  assign cur_s  = s_cur;
  assign prev_s = s_prev;

  always_comb begin
    trig_hit = 1'b0;
    unique case (trig_mode)
      2'b00:   trig_hit = have_prev && (prev_s < lvl_s) && (cur_s >= lvl_s);
      2'b01:   trig_hit = have_prev && (prev_s > lvl_s) && (cur_s <= lvl_s);
      default: trig_hit = cur_valid;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      busy_q   <= (state_d == WAIT_TRIG) || (state_d == CAPTURE);
      done_q   <= (state_d == DONE);
    end
  end

  // arm overrides everything, including a same-cycle trigger or final write.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    we       = 1'b0;
    if (arm) begin
      state_d  = WAIT_TRIG;
      wr_ptr_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        WAIT_TRIG: begin
          if (sample_en && trig_hit) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            state_d  = CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == AW'(DEPTH - 1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign wr_ptr = wr_ptr_q;

  // ---------------------------------------------------------------------------
  // Record RAM: one write port, one registered read port
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];

  // wr_ptr_q is 0 throughout WAIT_TRIG, so it also addresses the first write.
  always_ff @(posedge CLK_ADC) begin
    if (we) begin
      mem[wr_ptr_q] <= s_cur;
    end
  end

  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
